// File: rtl/ofifo_col_if.sv
// Bus between the MAC array bottom row, the per-column output FIFOs and the SFU stage.
// The master drives psum words, write strobes and row pops; the slave is the FIFO bank.
interface ofifo_col_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
);
    logic [col*psum_bw-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [col*psum_bw-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic [col-1:0]         overflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, overflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, overflow
    );
endinterface

// File: rtl/ofifo_col.sv
// Output FIFO bank: one FIFO per array column, written independently under skew,
// read back as whole rows (first-word fall-through) once every column holds data.
module ofifo_col #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 16
) (
    input logic        clk,
    input logic        reset,
    ofifo_col_if.slave bus
);
    localparam int unsigned aw = $clog2(depth);
    localparam logic [aw:0]   full_cnt = (aw + 1)'(depth);
    localparam logic [aw:0]   one_cnt  = (aw + 1)'(1);
    localparam logic [aw-1:0] one_ptr  = aw'(1);

    logic [psum_bw-1:0]     mem [col][depth];
    logic [col-1:0][aw-1:0] wr_ptr_q;
    logic [col-1:0][aw-1:0] rd_ptr_q;
    logic [col-1:0][aw:0]   cnt_q;
    logic [col-1:0][aw:0]   cnt_d;
    logic [col-1:0]         overflow_q;
    logic [col-1:0]         not_empty;
    logic [col-1:0]         is_full;
    logic [col-1:0]         accept;
    logic                   valid;
    logic                   pop;

    always_comb begin
        for (int unsigned i = 0; i < col; i++) begin
            not_empty[i] = (cnt_q[i] != '0);
            is_full[i]   = (cnt_q[i] == full_cnt);
        end
    end

    assign valid = &not_empty;
    assign pop   = bus.rd & valid;

    // A full column can still take a write when the same edge pops a row.
    always_comb begin
        for (int unsigned i = 0; i < col; i++) begin
            accept[i] = bus.wr[i] & (~is_full[i] | pop);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < col; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({accept[i], pop})
                2'b10:   cnt_d[i] = cnt_q[i] + one_cnt;
                2'b01:   cnt_d[i] = cnt_q[i] - one_cnt;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            for (int unsigned i = 0; i < col; i++) begin
                if (accept[i]) wr_ptr_q[i] <= wr_ptr_q[i] + one_ptr;
                if (pop)       rd_ptr_q[i] <= rd_ptr_q[i] + one_ptr;
                overflow_q[i] <= overflow_q[i] | (bus.wr[i] & ~accept[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < col; i++) begin
            if (accept[i] && !reset) mem[i][wr_ptr_q[i]] <= bus.in[i*psum_bw +: psum_bw];
        end
    end

    always_comb begin
        bus.out = '0;
        if (valid) begin
            for (int unsigned i = 0; i < col; i++) begin
                bus.out[i*psum_bw +: psum_bw] = mem[i][rd_ptr_q[i]];
            end
        end
    end

    assign bus.o_valid  = valid;
    assign bus.o_full   = |is_full;
    assign bus.o_ready  = ~|is_full;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ofifo_col.sv
// Bench for ofifo_col: directed scenarios plus random traffic, all checked against
// a queue-per-column model of the row-aligned FIFO bank.
module tb_ofifo_col;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ofifo_col_if #(.col(COL), .psum_bw(BW)) bus ();

    ofifo_col #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0]  mq [COL][$];
    logic [COL-1:0] m_ovf;

    function automatic bit m_valid();
        for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < COL; i++) if (mq[i].size() == DEP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [COL*BW-1:0] m_out();
        logic [COL*BW-1:0] o = '0;
        if (m_valid()) for (int i = 0; i < COL; i++) o[i*BW +: BW] = mq[i][0];
        return o;
    endfunction

    function automatic logic [COL*BW-1:0] rep(input logic [BW-1:0] w);
        logic [COL*BW-1:0] o;
        for (int i = 0; i < COL; i++) o[i*BW +: BW] = w;
        return o;
    endfunction

    function automatic logic [COL*BW-1:0] rnd_row();
        logic [COL*BW-1:0] o;
        for (int i = 0; i < COL; i++) o[i*BW +: BW] = BW'($urandom);
        return o;
    endfunction

    // Drive one cycle, advance the model by the same edge, settle 1 time unit past it.
    task automatic step(input logic rst, input logic [COL-1:0] w, input logic [COL*BW-1:0] d,
                        input logic r);
        bit pop;
        reset  = rst;
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < COL; i++) mq[i].delete();
            m_ovf = '0;
        end else begin
            pop = r && m_valid();
            for (int i = 0; i < COL; i++) begin
                bit acc;
                acc = w[i] && (mq[i].size() < DEP || pop);
                if (pop) void'(mq[i].pop_front());
                if (acc) mq[i].push_back(d[i*BW +: BW]);
                else if (w[i]) m_ovf[i] = 1'b1;
            end
        end
        #1;
        reset  = 1'b0;
        bus.wr = '0;
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, '0, '0, 1'b0);
        checks++; if (bus.o_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_ready !== 1'b1) begin failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
        checks++; if (bus.o_full !== 1'b0) begin failures++;
            $display("FAIL reset_full got=%b exp=0", bus.o_full); end
        checks++; if (bus.out !== '0) begin failures++;
            $display("FAIL reset_out got=%h exp=0", bus.out); end
        checks++; if (bus.overflow !== '0) begin failures++;
            $display("FAIL reset_ovf got=%h exp=0", bus.overflow); end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '0, '0, 1'b1);
            checks++;
            if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_full !== 1'b0 ||
                bus.out !== '0 || bus.overflow !== '0) begin
                failures++;
                $display("FAIL idle_rd v=%b r=%b f=%b out=%h ovf=%h exp v=0 r=1 f=0 out=0 ovf=0",
                         bus.o_valid, bus.o_ready, bus.o_full, bus.out, bus.overflow);
            end
        end
    endtask

    task automatic test_skew();
        logic [COL*BW-1:0] d;
        logic [COL*BW-1:0] exp_row;
        for (int i = 0; i < COL; i++) begin
            d = '0;
            d[i*BW +: BW] = 16'h0100 + BW'(i);
            exp_row[i*BW +: BW] = 16'h0100 + BW'(i);
            step(1'b0, COL'(1) << i, d, 1'b0);
            checks++; if (bus.o_valid !== (i == COL - 1)) begin failures++;
                $display("FAIL skew_valid col=%0d got=%b exp=%b", i, bus.o_valid, i == COL - 1); end
        end
        checks++; if (bus.out !== exp_row) begin failures++;
            $display("FAIL skew_out got=%h exp=%h", bus.out, exp_row); end
        step(1'b0, '0, '0, 1'b1);
        checks++; if (bus.o_valid !== 1'b0) begin failures++;
            $display("FAIL skew_pop_valid got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < DEP; k++) step(1'b0, '1, rep(BW'(k)), 1'b0);
        checks++; if (bus.o_full !== 1'b1 || bus.o_ready !== 1'b0) begin failures++;
            $display("FAIL fill_full full=%b ready=%b exp full=1 ready=0", bus.o_full, bus.o_ready); end
        for (int k = 0; k < DEP; k++) begin
            checks++; if (bus.out !== rep(BW'(k))) begin failures++;
                $display("FAIL fill_row k=%0d got=%h exp=%h", k, bus.out, rep(BW'(k))); end
            step(1'b0, '0, '0, 1'b1);
        end
        checks++; if (bus.o_valid !== 1'b0) begin failures++;
            $display("FAIL fill_empty got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_overflow();
        logic [COL*BW-1:0] d;
        for (int k = 0; k < DEP; k++) step(1'b0, '1, rnd_row(), 1'b0);
        d = rnd_row();
        d[3*BW +: BW] = 16'hDEAD;
        step(1'b0, 8'h08, d, 1'b0);
        checks++; if (bus.overflow !== 8'h08) begin failures++;
            $display("FAIL ovf_flag got=%h exp=08", bus.overflow); end
        for (int k = 0; k < DEP; k++) begin
            checks++; if (bus.out !== m_out() || bus.out[3*BW +: BW] === 16'hDEAD) begin
                failures++; $display("FAIL ovf_read k=%0d got=%h exp=%h", k, bus.out, m_out()); end
            step(1'b0, '0, '0, 1'b1);
        end
        for (int c = 0; c < 20; c++) step(1'b0, COL'($urandom) & 8'hF7, rnd_row(), $urandom_range(0, 1) == 1);
        checks++; if (bus.overflow !== 8'h08) begin failures++;
            $display("FAIL ovf_sticky got=%h exp=08", bus.overflow); end
        step(1'b1, '0, '0, 1'b0);
        checks++; if (bus.overflow !== '0) begin failures++;
            $display("FAIL ovf_clear got=%h exp=00", bus.overflow); end
    endtask

    task automatic test_simul_full();
        logic [COL*BW-1:0] d;
        for (int k = 0; k < DEP; k++) step(1'b0, '1, rnd_row(), 1'b0);
        d = '0;
        d[3*BW +: BW] = 16'hBEEF;
        step(1'b0, 8'h08, d, 1'b1);
        checks++; if (bus.overflow !== '0) begin failures++;
            $display("FAIL simul_ovf got=%h exp=00", bus.overflow); end
        checks++; if (bus.o_full !== 1'b1) begin failures++;
            $display("FAIL simul_full got=%b exp=1", bus.o_full); end
        // Keep the other columns topped up so BEEF reaches the head of a valid row.
        for (int k = 1; k <= DEP; k++) begin
            checks++; if (bus.out !== m_out()) begin failures++;
                $display("FAIL simul_row k=%0d got=%h exp=%h", k, bus.out, m_out()); end
            if (k == DEP) begin
                checks++; if (bus.out[3*BW +: BW] !== 16'hBEEF) begin failures++;
                    $display("FAIL simul_beef got=%h exp=beef", bus.out[3*BW +: BW]); end
            end
            step(1'b0, 8'hF7, rnd_row(), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        logic [COL*BW-1:0] d;
        step(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, '1, rnd_row(), 1'b0);
        step(1'b1, '1, rnd_row(), 1'b1);
        checks++; if (bus.o_valid !== 1'b0 || bus.o_full !== 1'b0 || bus.out !== '0) begin
            failures++; $display("FAIL rst_mid v=%b f=%b out=%h exp v=0 f=0 out=0",
                                 bus.o_valid, bus.o_full, bus.out); end
        d = rnd_row();
        step(1'b0, '1, d, 1'b0);
        checks++; if (bus.o_valid !== 1'b1 || bus.out !== d) begin failures++;
            $display("FAIL rst_mid_first v=%b got=%h exp=%h", bus.o_valid, bus.out, d); end
    endtask

    task automatic test_random();
        logic [COL-1:0] w;
        bit r;
        step(1'b1, '0, '0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            w = COL'($urandom);
            // Phases alternate between filling faster and draining faster.
            r = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 199) == 0, w, rnd_row(), r);
            checks++;
            if (bus.out !== m_out() || bus.o_valid !== m_valid() || bus.o_full !== m_full() ||
                bus.o_ready !== !m_full() || bus.overflow !== m_ovf) begin
                failures++;
                $display("FAIL rand c=%0d out=%h v=%b f=%b r=%b ovf=%h exp out=%h v=%b f=%b ovf=%h",
                         c, bus.out, bus.o_valid, bus.o_full, bus.o_ready, bus.overflow,
                         m_out(), m_valid(), m_full(), m_ovf);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        bus.wr = '0;
        bus.in = '0;
        bus.rd = 1'b0;
        m_ovf  = '0;
        test_reset();
        test_skew();
        test_fill();
        test_overflow();
        test_simul_full();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ofifo_col.md
Name: ofifo_col

Overview:
- Output FIFO bank directly downstream of the bottom row of the WS/OS reconfigurable MAC array.
- One independent FIFO per column captures that column's psum (WS: `out_s` of the last row; OS: drained `c_q` words) whenever that column asserts its write strobe.
- Columns finish at skewed times. The block re-aligns them and presents one full row (all columns) per read to the SFU/accumulation stage.

Parameters:
- col, 8, number of array columns (independent FIFOs).
- psum_bw, 16, width of one psum word.
- depth, 16, entries per column FIFO; must be a power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  col*psum_bw  psum words; column i occupies bits [(i+1)*psum_bw-1 : i*psum_bw].
- wr  input  col  per-column write strobe; bit i writes column i's slice of `in`.
- rd  input  1  pop one row (one entry from every column).
- out  output  col*psum_bw  head entry of each column, same column packing as `in`.
- o_valid  output  1  every column FIFO is non-empty.
- o_full  output  1  at least one column FIFO is full.
- o_ready  output  1  no column FIFO is full; equals ~o_full.
- overflow  output  col  sticky per-column flag: a write was dropped on that column.

Behaviour:
- Storage and pointers:
  - Per column: memory of depth x psum_bw, wr_ptr and rd_ptr of log2(depth) bits, cnt of log2(depth)+1 bits.
  - Pointers wrap from depth-1 to 0 naturally.
- Reset (synchronous, active-high):
  - All pointers and counts go to 0; overflow goes to 0.
  - Memory contents are don't-care.
  - Outputs in the cycle after reset: o_valid=0, o_full=0, o_ready=1, out=0, overflow=0.
  - Reset asserted mid-operation discards all stored data in the same edge. Any wr/rd sampled together with reset is ignored.
- Read/pop:
  - A pop occurs only when rd=1 and o_valid=1. It then advances rd_ptr of every column by 1.
  - rd=1 with o_valid=0 is ignored; no state change.
- Output data (first-word fall-through, combinational from state):
  - out = memory[rd_ptr] of each column when o_valid=1.
  - out = 0 when o_valid=0.
  - Data written on edge N is visible at out after edge N, provided the other columns are non-empty.
- Write acceptance, per column i:
  - A write is accepted when wr[i]=1 and (cnt_i < depth, or a pop occurs in the same cycle).
  - An accepted write stores in[i] at wr_ptr_i, then increments wr_ptr_i.
  - wr[i]=1 on a full column with no same-cycle pop: the write is dropped, overflow[i] is set, and it stays set until reset.
- Count update, per column:
  - cnt += accepted_write - pop.
  - Simultaneous write and pop leaves cnt unchanged, including when cnt=depth.
- Flags, all combinational from cnt:
  - o_valid = AND over columns of (cnt_i != 0).
  - o_full = OR over columns of (cnt_i == depth).
  - o_ready = ~o_full.
- Independence: columns are written independently, so skew between columns is absorbed as long as no column exceeds depth entries ahead of the slowest column.
- Latency: write to out, 1 cycle (after the slowest column's write).
- Empty column: cannot be popped, because pop requires every column to be non-empty.

Test Plan:
- Reset then idle: o_valid=0, o_ready=1, o_full=0, out=0, overflow=0. Then rd=1 for 3 cycles -> no change in any output.
- Skewed column fill (col=8): wr[i] pulses at cycle t+i with data 16'h0100+i. Expected:
  - o_valid stays 0 through cycle t+7.
  - o_valid rises after the edge at t+7.
  - out = {16'h0107,...,16'h0100}.
  - One rd -> o_valid=0.
- Fill to full: write all columns 16 times with data k=0..15. Expected:
  - o_full=1 and o_ready=0 after the 16th write.
  - Reading 16 rows returns k=0..15 in order, including across the pointer wrap.
  - o_valid=0 afterward.
- Overflow: column 3 full; wr[3]=1 with 16'hDEAD and rd=0. Expected:
  - overflow=8'h08.
  - Subsequent reads never return 16'hDEAD.
  - overflow stays set until reset.
- Simultaneous write and pop at full: column 3 full, rd=1 and wr[3]=1 with 16'hBEEF. Expected:
  - Write accepted and cnt_3 stays 16.
  - overflow[3] stays 0.
  - 16'hBEEF appears as the 16th subsequent row for column 3.
- Reset mid-operation: 5 rows stored; assert reset for 1 cycle together with wr=8'hFF and rd=1. Expected:
  - o_valid=0 and o_full=0 after the reset edge.
  - The next row written is read back first.
